// File: rtl/vchk_pkg.sv
// Shared definitions for the vector checker: FSM state encoding, parameter
// defaults and a small elaboration-time helper.
package vchk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         DEF_N_IN      = 2;
  localparam logic [3:0] DEF_EXP_TT    = 4'b1000;
  localparam int         DEF_INIT_WAIT = 10;
  localparam int         DEF_SETTLE    = 2;
  localparam int         DEF_ERR_W     = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count state: holds at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/vector_checker.sv
// Exhaustive truth-table checker: walks every input vector through an external
// unit, compares its response against EXP_TT and reports count and first failure.
module vector_checker
  import vchk_pkg::*;
#(
  parameter int                   N_IN      = DEF_N_IN,
  parameter logic [(2**N_IN)-1:0] EXP_TT    = DEF_EXP_TT,
  parameter int                   INIT_WAIT = DEF_INIT_WAIT,
  parameter int                   SETTLE    = DEF_SETTLE,
  parameter int                   ERR_W     = DEF_ERR_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic [N_IN-1:0]  o_dut_in,
  input  logic             i_dut_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_errors,
  output logic             o_fail_valid,
  output logic [N_IN-1:0]  o_fail_vec
);

  localparam int CNT_MAX = max2(INIT_WAIT, SETTLE + 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'((2 ** N_IN) - 1);

  logic [1:0]       r_rst_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N_IN:0]    r_idx;
  logic [N_IN-1:0]  r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail_valid;
  logic [N_IN-1:0]  r_fail_vec;
  logic             r_mis_pend;
  logic [N_IN-1:0]  r_mis_idx;
  logic             r_fin;

  logic             w_rst_ok;
  logic             w_start_ok;
  logic [N_IN:0]    w_idx_next;
  logic [ERR_W-1:0] w_errors;

  assign w_rst_ok   = r_rst_sync[1];
  assign w_idx_next = r_idx + (N_IN + 1)'(1);
  // r_fin marks the single result-settling cycle in DONE; start waits until done is up.
  assign w_start_ok = i_start & w_rst_ok &
                      ((r_state == ST_IDLE) | ((r_state == ST_DONE) & ~r_fin));

  // Two-flop release of the async reset before the FSM may leave IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start_ok),
    .i_inc   (r_mis_pend),
    .o_count (w_errors)
  );

  // Sequencer FSM; a mismatch is registered at the sample edge and booked one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_dut_in     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
      r_mis_pend   <= 1'b0;
      r_mis_idx    <= '0;
      r_fin        <= 1'b0;
    end else begin
      r_mis_pend <= 1'b0;
      if (r_mis_pend && !r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_vec   <= r_mis_idx;
      end
      if (w_start_ok) begin
        r_state      <= ST_WAIT;
        r_cnt        <= '0;
        r_idx        <= '0;
        r_dut_in     <= '0;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_pass       <= 1'b0;
        r_fail_valid <= 1'b0;
        r_fail_vec   <= '0;
        r_fin        <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT: begin
            if (r_cnt == CNT_W'(INIT_WAIT - 1)) begin
              r_state  <= ST_APPLY;
              r_cnt    <= '0;
              r_idx    <= '0;
              r_dut_in <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_APPLY: begin
            if (r_cnt == CNT_W'(SETTLE)) begin
              r_mis_pend <= (i_dut_out != EXP_TT[r_idx[N_IN-1:0]]);
              r_mis_idx  <= r_idx[N_IN-1:0];
              r_cnt      <= '0;
              if (r_idx == LAST_IDX) begin
                r_state  <= ST_DONE;
                r_fin    <= 1'b1;
                r_dut_in <= '0;
              end else begin
                r_idx    <= w_idx_next;
                r_dut_in <= w_idx_next[N_IN-1:0];
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_DONE: begin
            if (r_fin) begin
              r_fin  <= 1'b0;
              r_done <= 1'b1;
              r_busy <= 1'b0;
              // Counter is zero after this edge only if it is zero now and nothing is pending.
              r_pass <= (w_errors == '0) && !r_mis_pend;
            end else begin
              r_fin <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_dut_in     = r_dut_in;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_errors     = w_errors;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench: each run pushes hand-computed results; a monitor pops on done.
module tb_vector_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  int         mode = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic [1:0] dut_in_a, dut_in_b, fvec_a, fvec_b;
  logic       dut_out_a, dut_out_b;
  logic       busy_a, done_a, pass_a, fv_a;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [7:0] errs_a;
  logic [0:0] errs_b;

  typedef struct {
    int exp_cyc;
    int errors;
    int pass;
    int fv;
    int fvec;
    int errors1;
  } exp_t;

  exp_t sb[$];

  function automatic logic model(input int m, input logic [1:0] v);
    case (m)
      0: return v[1] & v[0];
      1: return 1'b0;
      2: return 1'b1;
      default: return v[0];
    endcase
  endfunction

  assign dut_out_a = model(mode, dut_in_a);
  assign dut_out_b = model(mode, dut_in_b);

  vector_checker u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_dut_in(dut_in_a), .i_dut_out(dut_out_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_errors(errs_a), .o_fail_valid(fv_a), .o_fail_vec(fvec_a)
  );

  vector_checker #(.ERR_W(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_dut_in(dut_in_b), .i_dut_out(dut_out_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_errors(errs_b), .o_fail_valid(fv_b), .o_fail_vec(fvec_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per rising edge of done.
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a && !prev_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc, e.exp_cyc);
          chk("busy_at_done", int'(busy_a), 0);
          chk("errors", int'(errs_a), e.errors);
          chk("pass", int'(pass_a), e.pass);
          chk("fail_valid", int'(fv_a), e.fv);
          chk("fail_vec", int'(fvec_a), e.fvec);
          chk("done_w1", int'(done_b), 1);
          chk("errors_w1", int'(errs_b), e.errors1);
          chk("fail_vec_w1", int'(fvec_b), e.fvec);
        end
      end
      prev_done = done_a;
    end
  end

  task automatic push_exp(input int errors, input int pass, input int fv,
                          input int fvec, input int e1);
    exp_t e;
    e.exp_cyc = cyc + 24;
    e.errors  = errors;
    e.pass    = pass;
    e.fv      = fv;
    e.fvec    = fvec;
    e.errors1 = e1;
    sb.push_back(e);
  endtask

  task automatic wait_empty();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(input int m, input int errors, input int pass,
                     input int fv, input int fvec, input int e1);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    push_exp(errors, pass, fv, fvec, e1);
    @(negedge clk);
    start = 1'b0;
    wait_empty();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_pass"}, int'(pass_a), 0);
    chk({tag, "_errors"}, int'(errs_a), 0);
    chk({tag, "_fail_valid"}, int'(fv_a), 0);
    chk({tag, "_fail_vec"}, int'(fvec_a), 0);
    chk({tag, "_dut_in"}, int'(dut_in_a), 0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Ideal AND, stuck-at-0, stuck-at-1 (saturates at ERR_W=1), out=v[0].
    run(0, 0, 1, 0, 0, 0);
    run(1, 1, 0, 1, 3, 1);
    run(2, 3, 0, 1, 0, 1);

    // Restart from DONE after a failing run: results clear at the start edge.
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    push_exp(0, 1, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    chk("restart_done", int'(done_a), 0);
    chk("restart_busy", int'(busy_a), 1);
    chk("restart_errors", int'(errs_a), 0);
    chk("restart_fail_valid", int'(fv_a), 0);
    wait_empty();

    run(3, 1, 0, 1, 1, 1);

    // Start held high for the whole run; dropped on the cycle done is seen.
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    push_exp(0, 1, 0, 0, 0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_a) break;
    end
    start = 1'b0;
    wait_empty();
    repeat (30) @(negedge clk);

    // Async reset while vector 2 is applied in a failing run.
    @(negedge clk);
    mode  = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (dut_in_a == 2'd2) break;
      @(negedge clk);
    end
    chk("pre_reset_busy", int'(busy_a), 1);
    chk("pre_reset_errors_nonzero", int'(errs_a != 8'd0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run(0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
